flex_stp_framer: RTL and testbench
==================================

FLEX_STP_FRAMER -- requirements
Module: flex_stp_framer

Interface
REQ-001 Parameter NUM_BITS, default 8, data bits per frame; SHALL be legal from 2 to 32.
REQ-002 Parameter SHIFT_MSB, default 1; 1 means MSB-first (shift toward bit NUM_BITS-1), 0 means LSB-first (shift toward bit 0).
REQ-003 Parameter RESET_VAL, default all ones, reset and clear value of the shift register.
REQ-004 Ports: clk input 1, system clock, rising edge.
REQ-005 Ports: n_rst input 1, reset, synchronous and active-low.
REQ-006 Ports: serial_in input 1, serial data bit.
REQ-007 Ports: shift_enable input 1, sample serial_in this cycle.
REQ-008 Ports: clear input 1, abort the partial frame.
REQ-009 Ports: frame_ack input 1, consumer accepts frame_data.
REQ-010 Ports: parallel_out output NUM_BITS, live shift register contents.
REQ-011 Ports: frame_data output NUM_BITS, captured frame.
REQ-012 Ports: frame_valid output 1, frame_data holds an unaccepted frame.
REQ-013 Ports: overrun output 1, sticky flag set when a frame is lost.

Function
REQ-014 When shift_enable is 1, the shift register SHALL shift serial_in in by one position per clock, in the direction SHIFT_MSB selects; when shift_enable is 0 it SHALL hold.
REQ-015 The bit counter SHALL increment on each enabled shift and wrap to 0 when a frame completes; frame length is FRAME_LEN = NUM_BITS (NUM_BITS+1 with parity, see REQ-025).
REQ-016 Frame completion is the enabled shift that brings the counter to FRAME_LEN. On that edge, frame_data SHALL load the completed word, meaning the register value after the shift.
REQ-017 Output-buffer FSM states: EMPTY and FULL.
- EMPTY to FULL on completion.
- FULL to EMPTY on frame_ack with no completion in the same cycle.
- FULL stays FULL on completion plus frame_ack: the new word loads and frame_valid stays 1.
REQ-018 Completion while FULL without frame_ack SHALL overwrite frame_data with the newer frame and set overrun; overrun stays set until reset.
REQ-019 frame_ack while EMPTY SHALL be ignored.
REQ-020 frame_valid SHALL equal (state == FULL), registered, with one cycle latency from the completion edge.
REQ-021 clear SHALL load RESET_VAL into the shift register and zero the bit counter on the next edge, with priority over shift_enable. clear SHALL NOT affect frame_data, frame_valid or overrun.
REQ-022 parallel_out SHALL keep its existing behaviour, with no reset on frame completion: the next frame shifts over the old bits.

Reset
REQ-023 When n_rst is 0 at a rising clk edge:
- shift register = RESET_VAL;
- bit counter = 0;
- frame_data = RESET_VAL;
- state = EMPTY, so frame_valid = 0;
- overrun = 0.
Reset mid-frame discards the partial frame. There is no asynchronous path, so outputs keep their values until the next edge.

Configuration
REQ-024 Macro STP_PARITY_EN SHALL compile in even-parity framing and add the output parity_error (1 bit).
REQ-025 With STP_PARITY_EN defined:
- each frame is NUM_BITS data bits followed by one parity bit;
- the parity bit SHALL NOT enter the shift register;
- parity_error loads with the frame (1 if the data XOR parity bit is 1) and follows the frame_data update rules;
- reset value of parity_error is 0.
REQ-026 Without STP_PARITY_EN, the parity_error port and parity logic SHALL be absent and FRAME_LEN = NUM_BITS.

Structure
REQ-027 Package stp_pkg SHALL hold the obuf_state_t enum (EMPTY, FULL) and the constant STP_MAX_BITS = 32.
REQ-028 Bit counting SHALL live in sub-module stp_bit_counter, with:
- a parametrised width;
- inputs clear, count_enable and rollover_val;
- output rollover_flag.

Verification
REQ-029 Reset with NUM_BITS=4, SHIFT_MSB=1: hold n_rst=0 for 2 cycles -> parallel_out=4'hF, frame_valid=0, overrun=0; output unchanged between edges until a clk edge samples reset.
REQ-030 MSB-first stream 1,0,1,1 with contiguous enable -> parallel_out=4'b1011; frame_valid=1 one cycle after the 4th shift; frame_data=4'b1011; frame_ack clears frame_valid next cycle.
REQ-031 LSB-first (SHIFT_MSB=0), stream 1,0,0,0 with 1-cycle gaps between bits -> value holds during the gaps; final frame_data=4'b0001.
REQ-032 Two frames 4'hA then 4'h5 with no frame_ack -> frame_data=4'h5, overrun=1; then frame_ack -> frame_valid=0, overrun stays 1.
REQ-033 Send 2 bits, assert clear, then send 4'h3 -> frame_data=4'h3, with no early completion.
REQ-034 STP_PARITY_EN defined: send data 4'b0111 plus parity 1 -> parity_error=0; send data 4'b0111 plus parity 0 -> parity_error=1.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared types and constants for the flex_stp_framer serial-to-parallel framer.
package stp_pkg;

    // Output buffer occupancy: EMPTY means frame_data holds nothing unaccepted.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } obuf_state_t;

    // Widest supported data word.
    localparam int STP_MAX_BITS = 32;

    // Bit counter width: must hold STP_MAX_BITS + 1 (data plus optional parity bit).
    localparam int STP_CNT_W = $clog2(STP_MAX_BITS + 2);

endpackage

// File: rtl/stp_bit_counter.sv
// Frame bit counter: counts enabled shifts and wraps to 0 when the count
// reaches rollover_val. rollover_flag marks the enabled count that completes
// the frame, in the same cycle, so the framer can capture on that edge.
// clear has priority over count_enable and suppresses rollover.
module stp_bit_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_inc;

    // Next count: clear wins, otherwise increment and wrap on completion.
    always_comb begin
        count_inc     = count_q + WIDTH'(1);
        rollover_flag = count_enable && !clear && (count_inc == rollover_val);
        count_d       = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = rollover_flag ? '0 : count_inc;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/flex_stp_framer.sv
// Flexible serial-to-parallel framer with a one-entry output buffer.
// Shifts serial_in into a NUM_BITS register (direction set by SHIFT_MSB),
// captures each completed frame into frame_data, and flags lost frames with
// a sticky overrun bit.
// Optional feature: define STP_PARITY_EN for even-parity framing (one parity
// bit after the data bits, reported on parity_error).
module flex_stp_framer
    import stp_pkg::*;
#(
    parameter int                  NUM_BITS  = 8,
    parameter int                  SHIFT_MSB = 1,
    parameter logic [NUM_BITS-1:0] RESET_VAL = '1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic                shift_enable,
    input  logic                clear,
    input  logic                frame_ack,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [NUM_BITS-1:0] frame_data,
    output logic                frame_valid,
    output logic                overrun
`ifdef STP_PARITY_EN
    ,
    output logic                parity_error
`endif
);

`ifdef STP_PARITY_EN
    localparam int FRAME_LEN = NUM_BITS + 1;
`else
    localparam int FRAME_LEN = NUM_BITS;
`endif
    localparam logic [STP_CNT_W-1:0] FRAME_LEN_C = STP_CNT_W'(FRAME_LEN);
    localparam logic [STP_CNT_W-1:0] NUM_BITS_C  = STP_CNT_W'(NUM_BITS);

    logic [NUM_BITS-1:0]  sr_q, sr_d;
    logic [NUM_BITS-1:0]  frame_data_q, frame_data_d;
    obuf_state_t          state_q, state_d;
    logic                 overrun_q, overrun_d;
    logic [STP_CNT_W-1:0] bit_cnt;
    logic                 frame_done;
    logic                 data_phase;
`ifdef STP_PARITY_EN
    logic                 parity_error_q, parity_error_d;
`endif

    stp_bit_counter #(
        .WIDTH (STP_CNT_W)
    ) u_bit_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .count_enable  (shift_enable),
        .rollover_val  (FRAME_LEN_C),
        .count_out     (bit_cnt),
        .rollover_flag (frame_done)
    );

    // Only data bits enter the shift register; the parity bit slot (count ==
    // NUM_BITS) exists only in parity builds, so this is always true otherwise.
    assign data_phase = (bit_cnt < NUM_BITS_C);

    // Shift register next value; clear restores RESET_VAL ahead of shifting.
    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = RESET_VAL;
        end else if (shift_enable && data_phase) begin
            if (SHIFT_MSB != 0) begin
                sr_d = {sr_q[NUM_BITS-2:0], serial_in};
            end else begin
                sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    // Output buffer FSM: capture on completion, release on frame_ack.
    // The completed word is sr_d (post-shift value); in parity builds the
    // completing edge carries the parity bit, so sr_d equals sr_q there.
    always_comb begin
        state_d      = state_q;
        frame_data_d = frame_data_q;
        overrun_d    = overrun_q;
`ifdef STP_PARITY_EN
        parity_error_d = parity_error_q;
        if (frame_done) begin
            parity_error_d = (^sr_q) ^ serial_in;
        end
`endif
        case (state_q)
            EMPTY: begin
                if (frame_done) begin
                    frame_data_d = sr_d;
                    state_d      = FULL;
                end
            end
            FULL: begin
                if (frame_done) begin
                    frame_data_d = sr_d;
                    if (!frame_ack) begin
                        overrun_d = 1'b1;
                    end
                end else if (frame_ack) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr_q         <= RESET_VAL;
            frame_data_q <= RESET_VAL;
            state_q      <= EMPTY;
            overrun_q    <= 1'b0;
`ifdef STP_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            sr_q         <= sr_d;
            frame_data_q <= frame_data_d;
            state_q      <= state_d;
            overrun_q    <= overrun_d;
`ifdef STP_PARITY_EN
            parity_error_q <= parity_error_d;
`endif
        end
    end

    assign parallel_out = sr_q;
    assign frame_data   = frame_data_q;
    assign frame_valid  = (state_q == FULL);
    assign overrun      = overrun_q;
`ifdef STP_PARITY_EN
    assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_flex_stp_framer.sv
// Bench for flex_stp_framer: one MSB-first and one LSB-first instance share
// stimulus; a behavioural model tracks both and directed plus random
// scenarios compare against it and against hand-derived constants.
module tb_flex_stp_framer;

    localparam int              NB = 4;
    localparam logic [NB-1:0]   RV = 4'hF;
`ifdef STP_PARITY_EN
    localparam int              FL = NB + 1;
`else
    localparam int              FL = NB;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b0;
    logic shift_enable = 1'b0;
    logic clear = 1'b0;
    logic frame_ack = 1'b0;

    logic [NB-1:0] po_m, fd_m, po_l, fd_l;
    logic          fv_m, ov_m, fv_l, ov_l;
`ifdef STP_PARITY_EN
    logic          pe_m, pe_l;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [NB-1:0] m_sr_m = '0, m_sr_l = '0, m_fd_m = '0, m_fd_l = '0;
    logic          m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    flex_stp_framer #(.NUM_BITS(NB), .SHIFT_MSB(1), .RESET_VAL(RV)) u_msb (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .shift_enable (shift_enable),
        .clear        (clear),
        .frame_ack    (frame_ack),
        .parallel_out (po_m),
        .frame_data   (fd_m),
        .frame_valid  (fv_m),
        .overrun      (ov_m)
`ifdef STP_PARITY_EN
        ,
        .parity_error (pe_m)
`endif
    );

    flex_stp_framer #(.NUM_BITS(NB), .SHIFT_MSB(0), .RESET_VAL(RV)) u_lsb (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .shift_enable (shift_enable),
        .clear        (clear),
        .frame_ack    (frame_ack),
        .parallel_out (po_l),
        .frame_data   (fd_l),
        .frame_valid  (fv_l),
        .overrun      (ov_l)
`ifdef STP_PARITY_EN
        ,
        .parity_error (pe_l)
`endif
    );

    // Model: applies one clock edge of the framing rules to both directions.
    task automatic model_edge(input logic sin, input logic en, input logic clr, input logic ack);
        bit done;
        done = 0;
        if (!n_rst) begin
            m_sr_m = RV; m_sr_l = RV; m_fd_m = RV; m_fd_l = RV;
            m_cnt = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
        end else begin
            if (clr) begin
                m_sr_m = RV; m_sr_l = RV; m_cnt = 0;
            end else if (en) begin
                if (m_cnt < NB) begin
                    m_sr_m = NB'((m_sr_m << 1) | NB'(sin));
                    m_sr_l = (m_sr_l >> 1) | (NB'(sin) << (NB - 1));
                end
                m_cnt = m_cnt + 1;
                if (m_cnt == FL) begin
                    m_cnt = 0;
                    done = 1;
                end
            end
            if (done) begin
                if (m_valid && !ack) m_ovr = 1;
                m_valid = 1;
                m_fd_m = m_sr_m;
                m_fd_l = m_sr_l;
                m_perr = (FL > NB) ? ((^m_sr_m) ^ sin) : 1'b0;
            end else if (ack) begin
                m_valid = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic cycle(input logic sin, input logic en, input logic clr, input logic ack);
        serial_in = sin; shift_enable = en; clear = clr; frame_ack = ack;
        @(posedge clk);
        model_edge(sin, en, clr, ack);
        #1;
        serial_in = 0; shift_enable = 0; clear = 0; frame_ack = 0;
    endtask

    // Send a 4-bit word MSB-first in stream order, plus even parity if built in.
    task automatic send_word(input logic [NB-1:0] w, input logic ack_last);
        logic [NB-1:0] wv;
        wv = w;
        for (int i = NB - 1; i >= 0; i--) begin
            cycle(wv[i], 1'b1, 1'b0, (FL == NB && i == 0) ? ack_last : 1'b0);
        end
        if (FL > NB) cycle(^wv, 1'b1, 1'b0, ack_last);
    endtask

    task automatic test_reset();
        n_rst = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        checks++; if (po_m !== 4'hF) begin errors++; $display("FAIL reset_po_msb: got %h expected %h", po_m, 4'hF); end
        checks++; if (po_l !== 4'hF) begin errors++; $display("FAIL reset_po_lsb: got %h expected %h", po_l, 4'hF); end
        checks++; if (fd_m !== 4'hF) begin errors++; $display("FAIL reset_fd: got %h expected %h", fd_m, 4'hF); end
        checks++; if ({fv_m, ov_m, fv_l, ov_l} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {fv_m, ov_m, fv_l, ov_l}); end
        n_rst = 1;
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        checks++; if (po_m !== 4'hC) begin errors++; $display("FAIL pre_reset_po: got %h expected %h", po_m, 4'hC); end
        n_rst = 0;
        #3;
        checks++; if (po_m !== 4'hC) begin errors++; $display("FAIL reset_is_sync: got %h expected %h", po_m, 4'hC); end
        cycle(0, 0, 0, 0);
        checks++; if (po_m !== 4'hF) begin errors++; $display("FAIL reset_mid_frame: got %h expected %h", po_m, 4'hF); end
        n_rst = 1;
    endtask

    task automatic test_msb_stream();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            checks++; if (fv_m !== 1'b0) begin errors++; $display("FAIL msb_early_valid: got %b expected 0", fv_m); end
            cycle(bits[i], 1, 0, 0);
        end
        checks++; if (po_m !== 4'b1011) begin errors++; $display("FAIL msb_po: got %b expected 1011", po_m); end
        if (FL > NB) cycle(^bits, 1, 0, 0);
        checks++; if (fv_m !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b expected 1", fv_m); end
        checks++; if (fd_m !== 4'b1011) begin errors++; $display("FAIL msb_fd: got %b expected 1011", fd_m); end
        checks++; if (fd_l !== m_fd_l) begin errors++; $display("FAIL msb_fd_lsb_inst: got %b expected %b", fd_l, m_fd_l); end
        cycle(0, 0, 0, 1);
        checks++; if (fv_m !== 1'b0) begin errors++; $display("FAIL msb_ack: got %b expected 0", fv_m); end
    endtask

    task automatic test_lsb_gaps();
        logic [3:0] seq;
        logic [NB-1:0] held;
        seq = 4'b1000; // stream order 1,0,0,0 from bit 3 down
        for (int i = 3; i >= 0; i--) begin
            cycle(seq[i], 1, 0, 0);
            held = po_l;
            cycle(0, 0, 0, 0);
            checks++; if (po_l !== held) begin errors++; $display("FAIL lsb_gap_hold: got %b expected %b", po_l, held); end
        end
        if (FL > NB) cycle(1'b1, 1, 0, 0);
        checks++; if (fd_l !== 4'b0001) begin errors++; $display("FAIL lsb_fd: got %b expected 0001", fd_l); end
        checks++; if (fd_m !== m_fd_m) begin errors++; $display("FAIL lsb_fd_msb_inst: got %b expected %b", fd_m, m_fd_m); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_overrun();
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        checks++; if (fd_m !== 4'h5) begin errors++; $display("FAIL ovr_fd: got %h expected 5", fd_m); end
        checks++; if ({fv_m, ov_m, ov_l} !== 3'b111) begin errors++; $display("FAIL ovr_flags: got %b expected 111", {fv_m, ov_m, ov_l}); end
        cycle(0, 0, 0, 1);
        checks++; if ({fv_m, ov_m} !== 2'b01) begin errors++; $display("FAIL ovr_sticky: got %b expected 01", {fv_m, ov_m}); end
    endtask

    task automatic test_clear();
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 0);
        checks++; if (po_m !== 4'hF) begin errors++; $display("FAIL clear_po: got %h expected F", po_m); end
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        checks++; if (fv_m !== 1'b0) begin errors++; $display("FAIL clear_early_completion: got %b expected 0", fv_m); end
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        if (FL > NB) cycle(1'b0, 1, 0, 0);
        checks++; if ({fv_m, fd_m} !== {1'b1, 4'h3}) begin errors++; $display("FAIL clear_fd: got %b/%h expected 1/3", fv_m, fd_m); end
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        n_rst = 0;
        cycle(0, 0, 0, 0);
        n_rst = 1;
        cycle(0, 0, 0, 1); // ack while EMPTY is ignored
        send_word(4'h6, 0);
        send_word(4'h9, 1); // completion with ack in the same cycle
        checks++; if ({fv_m, ov_m, fd_m} !== {1'b1, 1'b0, 4'h9}) begin errors++; $display("FAIL b2b: got %b/%b/%h expected 1/0/9", fv_m, ov_m, fd_m); end
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        checks++; if ({fv_m, ov_m} !== 2'b00) begin errors++; $display("FAIL b2b_release: got %b expected 00", {fv_m, ov_m}); end
    endtask

`ifdef STP_PARITY_EN
    task automatic test_parity();
        cycle(0, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        checks++; if ({fv_m, fd_m, pe_m} !== {1'b1, 4'b0111, 1'b0}) begin errors++; $display("FAIL parity_good: got %b/%b/%b expected 1/0111/0", fv_m, fd_m, pe_m); end
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        checks++; if ({pe_m, pe_l} !== 2'b11) begin errors++; $display("FAIL parity_bad: got %b expected 11", {pe_m, pe_l}); end
        cycle(0, 0, 0, 1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            n_rst = ($urandom_range(0, 149) != 0);
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 3));
            checks++;
            if ({po_m, fd_m, fv_m, ov_m} !== {m_sr_m, m_fd_m, m_valid, m_ovr}) begin
                errors++;
                $display("FAIL rand_msb cyc %0d: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                         po_m, fd_m, fv_m, ov_m, m_sr_m, m_fd_m, m_valid, m_ovr);
            end
            checks++;
            if ({po_l, fd_l, fv_l, ov_l} !== {m_sr_l, m_fd_l, m_valid, m_ovr}) begin
                errors++;
                $display("FAIL rand_lsb cyc %0d: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                         po_l, fd_l, fv_l, ov_l, m_sr_l, m_fd_l, m_valid, m_ovr);
            end
`ifdef STP_PARITY_EN
            checks++;
            if ({pe_m, pe_l} !== {m_perr, m_perr}) begin
                errors++;
                $display("FAIL rand_parity cyc %0d: got %b%b expected %b", i, pe_m, pe_l, m_perr);
            end
`endif
        end
        n_rst = 1;
    endtask

    initial begin
        test_reset();
        test_msb_stream();
        test_lsb_gaps();
        test_overrun();
        test_clear();
        test_back_to_back();
`ifdef STP_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
